usart_tx_shifter: RTL and testbench
===================================

# usart_tx_shifter

USART transmit serializer sitting directly downstream of the TX FIFO. It pops bytes from the FIFO (combinational `dout`, non-synchronous output mode), frames each one with a start bit, 5–8 data bits, optional parity and 1–2 stop bits, and drives `txd` at the programmed baud rate. It also reports busy and transmit-complete status to the USART register block.

## Interface
- `DIV_W`, 12: width of the baud divisor `ubrr`. The internal bit timer is `DIV_W+4` bits wide.
- `cp2`, in, 1: system clock. All logic is on the rising edge.
- `ireset`, in, 1: synchronous, active-high reset.
- `txen`, in, 1: transmitter enable.
- `ubrr`, in, DIV_W: baud divisor.
- `u2x`, in, 1: 1 selects 8× oversampling, 0 selects 16×.
- `ucsz`, in, 2: character size. 00/01/10/11 give 5/6/7/8 data bits.
- `upm`, in, 2: parity mode. 00 and 01 mean none, 10 means even, 11 means odd.
- `usbs`, in, 1: 0 selects one stop bit, 1 selects two.
- `fifo_dout`, in, 8: head byte of the TX FIFO. Valid whenever `fifo_empty`=0.
- `fifo_empty`, in, 1: TX FIFO empty flag.
- `fifo_re`, out, 1: FIFO pop strobe. Combinational, one cycle per byte.
- `txd`, out, 1: serial output. Registered, idles high.
- `tx_busy`, out, 1: registered. High whenever the state is not IDLE.
- `txc`, out, 1: registered one-cycle pulse when the line goes idle after a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Bit period T = (`ubrr`+1) × (`u2x` ? 8 : 16) cycles. The timer loads T−1 on entry to each bit and counts down; the bit ends on the cycle the timer reads 0.
- Load condition: `txen`=1 and `fifo_empty`=0, evaluated in IDLE or in the last cycle of the last stop bit.
  - `fifo_re`=1 in that cycle.
  - The shift register captures `fifo_dout`.
  - `ubrr`, `u2x`, `ucsz`, `upm` and `usbs` are latched. They are held for the whole frame; changes mid-frame have no effect until the next load.
- `fifo_re` is never asserted while `fifo_empty`=1 or `txen`=0.
- START: `txd`=0 for one bit period.
- DATA: n = `ucsz`+5 bits, sent LSB first from the shift register. Bits above n−1 of the loaded byte are ignored.
- PARITY: entered only when latched `upm[1]`=1, for one bit period.
  - Even parity: `txd` = XOR of the n transmitted bits.
  - Odd parity: `txd` = inverse of that XOR.
- STOP: `txd`=1 for T (`usbs`=0) or 2T (`usbs`=1) cycles.
- End of the last stop bit:
  - If the load condition holds, go to START with no idle gap.
  - Otherwise go to IDLE and pulse `txc`.
- `txen` falling mid-frame: the current frame completes normally and no further byte is popped. `txc` pulses at the end of that frame; the FIFO contents are untouched.
- In IDLE, `txd`=1.

## Timing
- Reset values: `txd`=1, `tx_busy`=0, `txc`=0, `fifo_re`=0, state IDLE, timer 0. This holds even mid-frame; the line returns high on the cycle after reset is sampled.
- Pop at cycle N:
  - Start bit on `txd` during cycles N+1..N+T.
  - `tx_busy`=1 from N+1.
- Frame length: F = T × (1 + n + p + s) cycles, where p is the parity bit count (0 or 1) and s is the stop bit count. The frame occupies cycles N+1..N+F.
- Back-to-back frames:
  - Next `fifo_re` at cycle N+F.
  - Next start bit begins at N+F+1.
  - `tx_busy` stays high; no `txc` pulse.
- Last frame: `txc`=1 and `tx_busy`=0 at cycle N+F+1 only. `txc` returns to 0 at N+F+2.
- Timer maximum: T−1 = 2^(DIV_W+4)−1. No overflow is possible at DIV_W+4 bits.

## Test plan
- 8N1, `ubrr`=0, `u2x`=1 (T=8), FIFO holds 0x55, pop at cycle N:
  - `txd`=0 for N+1..N+8.
  - Data bits 1,0,1,0,1,0,1,0, each 8 cycles.
  - Stop bit high for N+73..N+80.
  - `txc` high at N+81 only.
- 7 data bits, even parity, 2 stop bits, T=8, byte 0x83:
  - Data bits 1,1,0,0,0,0,0 (bit 7 dropped).
  - Parity bit 0.
  - `txd` high for 16 cycles.
  - F=88.
- 5 data bits, odd parity, `ubrr`=3, `u2x`=0 (T=64), byte 0x07:
  - Data bits 1,1,1,0,0.
  - Parity bit 0.
  - Total frame 512 cycles.
- Two bytes 0xA5, 0x3C queued, 8N1, T=8:
  - `fifo_re` pulses at N and N+80.
  - Second start bit at N+81 with no gap.
  - Exactly one `txc`, at N+161.
- `txen` dropped at N+20 with 2 bytes queued: first frame completes, `txc` at N+81, no second `fifo_re`, `fifo_empty` stays 0.
- `ireset` asserted at N+30 mid-frame: `txd`=1, `tx_busy`=0 and `txc`=0 next cycle. After release with `txen`=1, the next queued byte is popped and sent as a fresh frame.

Source files
------------

// File: rtl/usart_tx_shifter.sv
// USART transmit serializer: pops the TX FIFO and frames each byte.
// Ports: cp2/ireset, txen, ubrr/u2x/ucsz/upm/usbs config, fifo_dout/fifo_empty/fifo_re, txd, tx_busy, txc.
module usart_tx_shifter #(
    parameter int DIV_W = 12
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic             txen,
    input  logic [DIV_W-1:0] ubrr,
    input  logic             u2x,
    input  logic [1:0]       ucsz,
    input  logic [1:0]       upm,
    input  logic             usbs,
    input  logic [7:0]       fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_re,
    output logic             txd,
    output logic             tx_busy,
    output logic             txc
);

    localparam int TW = DIV_W + 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [TW-1:0]    tmr;
    logic [DIV_W-1:0] ubrr_q;
    logic             u2x_q;
    logic [1:0]       ucsz_q;
    logic [1:0]       upm_q;
    logic             usbs_q;
    logic [7:0]       sr;
    logic [2:0]       cnt;
    logic             par;
    logic             stop2;
    logic             bit_end;
    logic             last_stop;
    logic             ld;
    logic [7:0]       din;

    // Bit period minus one: (ubrr+1)*8-1 or (ubrr+1)*16-1.
    function automatic logic [TW-1:0] per_m1(
        input logic [DIV_W-1:0] d,
        input logic             x2
    );
        return x2 ? {1'b0, d, 3'b111} : {d, 4'b1111};
    endfunction

    assign bit_end   = (tmr == '0);
    assign last_stop = (state == STOP) && bit_end && (!usbs_q || stop2);
    assign ld        = !ireset && txen && !fifo_empty &&
                       ((state == IDLE) || last_stop);
    assign fifo_re   = ld;

    // Drop the unused high bits up front so parity covers only sent bits.
    assign din = fifo_dout & (8'hFF >> (2'd3 - ucsz));

    always_ff @(posedge cp2) begin
        if (ireset) begin
            state   <= IDLE;
            tmr     <= '0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            txc     <= 1'b0;
            ubrr_q  <= '0;
            u2x_q   <= 1'b0;
            ucsz_q  <= 2'd0;
            upm_q   <= 2'd0;
            usbs_q  <= 1'b0;
            sr      <= 8'd0;
            cnt     <= 3'd0;
            par     <= 1'b0;
            stop2   <= 1'b0;
        end else begin
            txc <= 1'b0;
            if (ld) begin
                ubrr_q  <= ubrr;
                u2x_q   <= u2x;
                ucsz_q  <= ucsz;
                upm_q   <= upm;
                usbs_q  <= usbs;
                sr      <= din;
                par     <= ^din;
                tmr     <= per_m1(ubrr, u2x);
                state   <= START;
                txd     <= 1'b0;
                tx_busy <= 1'b1;
                stop2   <= 1'b0;
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    tmr <= tmr - 1'b1;
                end else begin
                    tmr <= per_m1(ubrr_q, u2x_q);
                    unique case (state)
                        IDLE: ;
                        START: begin
                            txd   <= sr[0];
                            sr    <= sr >> 1;
                            cnt   <= 3'd0;
                            state <= DATA;
                        end
                        DATA: begin
                            if (cnt == {1'b0, ucsz_q} + 3'd4) begin
                                stop2 <= 1'b0;
                                if (upm_q[1]) begin
                                    txd   <= par ^ upm_q[0];
                                    state <= PARITY;
                                end else begin
                                    txd   <= 1'b1;
                                    state <= STOP;
                                end
                            end else begin
                                txd <= sr[0];
                                sr  <= sr >> 1;
                                cnt <= cnt + 3'd1;
                            end
                        end
                        PARITY: begin
                            txd   <= 1'b1;
                            stop2 <= 1'b0;
                            state <= STOP;
                        end
                        STOP: begin
                            if (!last_stop) begin
                                stop2 <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                tmr     <= '0;
                                txd     <= 1'b1;
                                tx_busy <= 1'b0;
                                txc     <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_usart_tx_shifter.sv
// Directed bench for usart_tx_shifter with a small FIFO model.
// Checks frame bits, pop strobes, busy/txc timing and reset.
module tb_usart_tx_shifter;

    logic        cp2 = 1'b0;
    logic        ireset = 1'b1;
    logic        txen = 1'b0;
    logic [11:0] ubrr = 12'd0;
    logic        u2x = 1'b1;
    logic [1:0]  ucsz = 2'd3;
    logic [1:0]  upm = 2'd0;
    logic        usbs = 1'b0;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_re;
    logic        txd;
    logic        tx_busy;
    logic        txc;

    int vecs = 0;
    int errs = 0;

    logic [7:0] fmem [16];
    int rd = 0;
    int wr = 0;

    always #5 cp2 = ~cp2;

    assign fifo_dout  = fmem[rd[3:0]];
    assign fifo_empty = (rd == wr);

    always @(posedge cp2) if (fifo_re) rd <= rd + 1;

    usart_tx_shifter #(.DIV_W(12)) dut (
        .cp2        (cp2),
        .ireset     (ireset),
        .txen       (txen),
        .ubrr       (ubrr),
        .u2x        (u2x),
        .ucsz       (ucsz),
        .upm        (upm),
        .usbs       (usbs),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .txc        (txc)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr[3:0]] = b;
        wr++;
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (fifo_re) begin
                ok = 1'b1;
                break;
            end
            @(negedge cp2);
        end
        if (!ok) check("pop_timeout", 0, 1);
    endtask

    // pat[b] is the expected line level during bit b of the frame.
    task automatic frame(input string tag, input int t, input int nb,
                         input logic [15:0] pat, input bit nxt,
                         input int drop, input bit scramble);
        bit ok;
        int k;
        wait_pop(ok);
        if (!ok) return;
        for (int b = 0; b < nb; b++) begin
            for (int c = 1; c <= t; c++) begin
                @(negedge cp2);
                k = b * t + c;
                if (k == drop) txen = 1'b0;
                if (k == 1) begin
                    check({tag, "/re_once"}, fifo_re, 0);
                    if (scramble) begin
                        ubrr = 12'd7;
                        u2x  = 1'b1;
                        ucsz = 2'd0;
                        upm  = 2'd0;
                        usbs = 1'b1;
                    end
                end
                if (c == 1 || c == t)
                    check($sformatf("%s/txd_b%0d_c%0d", tag, b, c),
                          txd, pat[b]);
                if (c == 1)
                    check($sformatf("%s/busy_b%0d", tag, b), tx_busy, 1);
            end
        end
        #1;
        check({tag, "/re_end"}, fifo_re, nxt);
        check({tag, "/txc_end"}, txc, 0);
        if (!nxt) begin
            @(negedge cp2);
            check({tag, "/txc_pulse"}, txc, 1);
            check({tag, "/busy_idle"}, tx_busy, 0);
            check({tag, "/txd_idle"}, txd, 1);
            @(negedge cp2);
            check({tag, "/txc_clr"}, txc, 0);
        end
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 16; i++) fmem[i] = 8'h00;

        // Reset with data and txen present: no pop allowed.
        txen = 1'b1;
        push(8'h55);
        repeat (3) @(negedge cp2);
        #1;
        check("rst/fifo_re", fifo_re, 0);
        check("rst/txd", txd, 1);
        check("rst/busy", tx_busy, 0);
        check("rst/txc", txc, 0);
        txen   = 1'b0;
        ireset = 1'b0;
        @(negedge cp2);
        #1;
        check("txen0/fifo_re", fifo_re, 0);
        check("txen0/txd", txd, 1);

        // 8N1, T=8, 0x55
        txen = 1'b1;
        frame("8n1", 8, 10, 16'h02AA, 1'b0, 0, 1'b0);

        // 7E2, T=8, 0x83
        ucsz = 2'd2;
        upm  = 2'd2;
        usbs = 1'b1;
        push(8'h83);
        frame("7e2", 8, 11, 16'h0606, 1'b0, 0, 1'b0);

        // 5O1, T=64, 0x07, config scrambled mid-frame
        ubrr = 12'd3;
        u2x  = 1'b0;
        ucsz = 2'd0;
        upm  = 2'd3;
        usbs = 1'b0;
        push(8'h07);
        frame("5o1", 64, 8, 16'h008E, 1'b0, 0, 1'b1);

        // Back-to-back 0xA5, 0x3C
        ubrr = 12'd0;
        u2x  = 1'b1;
        ucsz = 2'd3;
        upm  = 2'd0;
        usbs = 1'b0;
        push(8'hA5);
        push(8'h3C);
        frame("b2b_a", 8, 10, 16'h034A, 1'b1, 0, 1'b0);
        frame("b2b_b", 8, 10, 16'h0278, 1'b0, 0, 1'b0);

        // txen dropped mid-frame with two bytes queued
        txen = 1'b0;
        push(8'hFF);
        push(8'h12);
        txen = 1'b1;
        frame("drop", 8, 10, 16'h03FE, 1'b0, 20, 1'b0);
        repeat (10) @(negedge cp2);
        #1;
        check("drop/fifo_re_hold", fifo_re, 0);
        check("drop/fifo_empty", fifo_empty, 0);
        check("drop/left", wr - rd, 1);

        // Reset mid-frame, then a fresh frame from the queue
        push(8'hC3);
        txen = 1'b1;
        wait_pop(ok);
        repeat (29) @(negedge cp2);
        check("mrst/txd_before", txd, 0);
        check("mrst/busy_before", tx_busy, 1);
        ireset = 1'b1;
        @(negedge cp2);
        check("mrst/txd", txd, 1);
        check("mrst/busy", tx_busy, 0);
        check("mrst/txc", txc, 0);
        #1;
        check("mrst/fifo_re", fifo_re, 0);
        ireset = 1'b0;
        frame("post_rst", 8, 10, 16'h0386, 1'b0, 0, 1'b0);
        check("end/fifo_empty", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
